// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: memory-wait FSM encoding, register-0 id, stage-control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Memory-access FSM states
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_e;

    // Architectural zero register; writes to it are discarded, so it never creates a dependence
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Number of stage-register control lines carried in ctrl_t
    localparam int CTRL_W = 7;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_bubble;
        logic ex_mem_hold;
        logic mem_wb_bubble;
    } ctrl_t;

    // True when a consumer register field actually depends on the producer destination
    function automatic logic reg_dep(input logic       uses,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory handshake sequencer (RUN/WAIT/ERR) with wait-state watchdog; emits ms, dmem_req, bus_err.
// Latency: outputs combinational from registered state and same-cycle mem_access/dmem_ack.
// Backpressure: ms asserts while a request is unacknowledged; ERR is a sticky full freeze until reset.
//
// Ports: clk, rst_n (sync, active-low), mem_access, dmem_ack -> ms, dmem_req, bus_err.
// Parameters: TIMEOUT (max WAIT cycles), TO_W (counter width, 2^TO_W > TIMEOUT).
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_access,
    input  logic dmem_ack,
    output logic ms,
    output logic dmem_req,
    output logic bus_err
);

    mem_state_e            state_q, state_d;
    logic       [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        unique case (state_q)
            RUN: begin
                // An ack on the issue cycle is a zero-wait access: stay in RUN
                if (mem_access && !dmem_ack) begin
                    state_d  = WAIT;
                    to_cnt_d = TO_W'(1);
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    // Pipeline advances on this edge, so the request is not reissued
                    state_d  = RUN;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
                    state_d = ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d  = RUN;
                to_cnt_d = '0;
            end
        endcase
    end

    assign ms = ((state_q == WAIT) && !dmem_ack)
             || ((state_q == RUN) && mem_access && !dmem_ack)
             || (state_q == ERR);
    assign dmem_req = mem_access && (state_q != ERR);
    assign bus_err  = (state_q == ERR);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use detect, memory-wait freeze, taken-branch squash.
// Latency: all controls combinational (same cycle); only FSM, watchdog and perf counters are registered.
// Backpressure: memory stall freezes PC..EX/MEM and bubbles MEM/WB; load-use holds PC/IF-ID and bubbles ID/EX.
//
// Ports: ID register fields/uses, EX load/destination/branch, MEM access/ack -> dmem_req, stage
//        hold/flush/bubble controls, bus_err. All outputs forced low while rst_n=0.
// Optional: HAZARD_PERF_EN adds saturating 32-bit perf_lu_cnt, perf_ms_cnt, perf_flush_cnt.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_rt_store_only,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_reg_w_addr,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_bubble,
    output logic        ex_mem_hold,
    output logic        mem_wb_bubble,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_ms_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        bus_err
);

    logic  ms, fsm_req, fsm_err;
    logic  lu;
    ctrl_t ctrl, ctrl_out;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_mem_wait_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_access (mem_access),
        .dmem_ack   (dmem_ack),
        .ms         (ms),
        .dmem_req   (fsm_req),
        .bus_err    (fsm_err)
    );

    // Store-data use of rt is covered by WB->MEM forwarding, so it is excluded here
    assign lu = ex_mem_read && (ex_reg_w_addr != REG_ZERO)
             && (reg_dep(id_uses_rs, id_rs_addr, ex_reg_w_addr)
              || reg_dep(id_uses_rt && !id_rt_store_only, id_rt_addr, ex_reg_w_addr));

    // Priority: memory freeze > branch squash > load-use stall.
    // A branch held in EX by the freeze is re-evaluated once the freeze lifts.
    always_comb begin
        ctrl = '0;
        if (ms) begin
            ctrl.pc_hold       = 1'b1;
            ctrl.if_id_hold    = 1'b1;
            ctrl.id_ex_hold    = 1'b1;
            ctrl.ex_mem_hold   = 1'b1;
            ctrl.mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
        end else if (lu) begin
            ctrl.pc_hold      = 1'b1;
            ctrl.if_id_hold   = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
        end
    end

    // Reset drops everything immediately, abandoning any outstanding request
    assign ctrl_out = rst_n ? ctrl : ctrl_t'({CTRL_W{1'b0}});

    assign pc_hold       = ctrl_out.pc_hold;
    assign if_id_hold    = ctrl_out.if_id_hold;
    assign if_id_flush   = ctrl_out.if_id_flush;
    assign id_ex_hold    = ctrl_out.id_ex_hold;
    assign id_ex_bubble  = ctrl_out.id_ex_bubble;
    assign ex_mem_hold   = ctrl_out.ex_mem_hold;
    assign mem_wb_bubble = ctrl_out.mem_wb_bubble;
    assign dmem_req      = rst_n && fsm_req;
    assign bus_err       = rst_n && fsm_err;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt_q,    perf_lu_cnt_d;
    logic [31:0] perf_ms_cnt_q,    perf_ms_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
    logic        lu_stall, br_flush;

    // Count only the event that actually drove the controls this cycle
    assign lu_stall = lu && !ms && !ex_branch_taken;
    assign br_flush = ex_branch_taken && !ms;

    always_comb begin
        perf_lu_cnt_d    = perf_lu_cnt_q;
        perf_ms_cnt_d    = perf_ms_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (lu_stall && (perf_lu_cnt_q != '1))
            perf_lu_cnt_d = perf_lu_cnt_q + 32'd1;
        if (ms && (perf_ms_cnt_q != '1))
            perf_ms_cnt_d = perf_ms_cnt_q + 32'd1;
        if (br_flush && (perf_flush_cnt_q != '1))
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lu_cnt_q    <= '0;
            perf_ms_cnt_q    <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_lu_cnt_q    <= perf_lu_cnt_d;
            perf_ms_cnt_q    <= perf_ms_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_lu_cnt    = perf_lu_cnt_q;
    assign perf_ms_cnt    = perf_ms_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table of single-cycle vectors plus multi-cycle memory sequences.
// Latency: outputs checked on the falling edge of the cycle the inputs were applied.
// Backpressure: n/a.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs_addr, id_rt_addr, ex_reg_w_addr;
    logic       id_uses_rs, id_uses_rt, id_rt_store_only;
    logic       ex_mem_read, ex_branch_taken, mem_access, dmem_ack;
    logic       dmem_req, pc_hold, if_id_hold, if_id_flush, id_ex_hold;
    logic       id_ex_bubble, ex_mem_hold, mem_wb_bubble, bus_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_ms_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(4), .TO_W(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs_addr       (id_rs_addr),
        .id_rt_addr       (id_rt_addr),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .id_rt_store_only (id_rt_store_only),
        .ex_mem_read      (ex_mem_read),
        .ex_reg_w_addr    (ex_reg_w_addr),
        .ex_branch_taken  (ex_branch_taken),
        .mem_access       (mem_access),
        .dmem_ack         (dmem_ack),
        .dmem_req         (dmem_req),
        .pc_hold          (pc_hold),
        .if_id_hold       (if_id_hold),
        .if_id_flush      (if_id_flush),
        .id_ex_hold       (id_ex_hold),
        .id_ex_bubble     (id_ex_bubble),
        .ex_mem_hold      (ex_mem_hold),
        .mem_wb_bubble    (mem_wb_bubble),
`ifdef HAZARD_PERF_EN
        .perf_lu_cnt      (perf_lu_cnt),
        .perf_ms_cnt      (perf_ms_cnt),
        .perf_flush_cnt   (perf_flush_cnt),
`endif
        .bus_err          (bus_err)
    );

    // Output vector: {dmem_req, pc_hold, if_id_hold, if_id_flush, id_ex_hold,
    //                 id_ex_bubble, ex_mem_hold, mem_wb_bubble, bus_err}
    localparam logic [8:0] O_NONE = 9'b0_0000_0000;
    localparam logic [8:0] O_REQ  = 9'b1_0000_0000;
    localparam logic [8:0] O_LU   = 9'b0_1100_1000;
    localparam logic [8:0] O_BR   = 9'b0_0010_1000;
    localparam logic [8:0] O_MS   = 9'b0_1101_0110;
    localparam logic [8:0] O_ERR  = 9'b0_1101_0111;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       ma, ack, br, exrd;
        logic [4:0] wa;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic       so;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[14];
    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string name, logic rn, logic ma, logic ack, logic br,
                                logic exrd, logic [4:0] wa, logic urs, logic [4:0] rs,
                                logic urt, logic [4:0] rt, logic so, logic [8:0] exp);
        vec_t v;
        v.name = name; v.rst_n = rn; v.ma = ma; v.ack = ack; v.br = br;
        v.exrd = exrd; v.wa = wa; v.urs = urs; v.rs = rs; v.urt = urt;
        v.rt = rt; v.so = so; v.exp = exp;
        return v;
    endfunction

    // Memory-side only vector: no ID/EX register dependence
    function automatic vec_t mm(string name, logic rn, logic ma, logic ack, logic br,
                                logic [8:0] exp);
        return mk(name, rn, ma, ack, br, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, exp);
    endfunction

    task automatic apply(input vec_t v);
        vec_t       e;
        logic [8:0] got;
        @(posedge clk);
        #1;
        rst_n            = v.rst_n;
        mem_access       = v.ma;
        dmem_ack         = v.ack;
        ex_branch_taken  = v.br;
        ex_mem_read      = v.exrd;
        ex_reg_w_addr    = v.wa;
        id_uses_rs       = v.urs;
        id_rs_addr       = v.rs;
        id_uses_rt       = v.urt;
        id_rt_addr       = v.rt;
        id_rt_store_only = v.so;
        sb_q.push_back(v);
        @(negedge clk);
        got = {dmem_req, pc_hold, if_id_hold, if_id_flush, id_ex_hold,
               id_ex_bubble, ex_mem_hold, mem_wb_bubble, bus_err};
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected entry, got %b", got);
        end else begin
            e = sb_q.pop_front();
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
            end
        end
    endtask

    initial begin
        //                 name           rn ma ack br exrd wa   urs rs   urt rt   so  exp
        tbl[0]  = mk("reset_quiet",       0, 1, 0, 1, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, O_NONE);
        tbl[1]  = mk("lu_rs",             1, 0, 0, 0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, O_LU);
        tbl[2]  = mk("lu_r0_dest",        1, 0, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, O_NONE);
        tbl[3]  = mk("lu_rs_mismatch",    1, 0, 0, 0, 1, 5'd8, 1, 5'd7, 0, 5'd8, 0, O_NONE);
        tbl[4]  = mk("no_load",           1, 0, 0, 0, 0, 5'd8, 1, 5'd8, 0, 5'd0, 0, O_NONE);
        tbl[5]  = mk("rs_unused",         1, 0, 0, 0, 1, 5'd8, 0, 5'd8, 0, 5'd0, 0, O_NONE);
        tbl[6]  = mk("store_data_exempt", 1, 0, 0, 0, 1, 5'd9, 1, 5'd3, 1, 5'd9, 1, O_NONE);
        tbl[7]  = mk("rt_alu_use",        1, 0, 0, 0, 1, 5'd9, 1, 5'd3, 1, 5'd9, 0, O_LU);
        tbl[8]  = mk("rt_unused",         1, 0, 0, 0, 1, 5'd9, 0, 5'd3, 0, 5'd9, 0, O_NONE);
        tbl[9]  = mk("branch_over_lu",    1, 0, 0, 1, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, O_BR);
        tbl[10] = mk("branch_only",       1, 0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, O_BR);
        tbl[11] = mk("zero_wait",         1, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, O_REQ);
        tbl[12] = mk("zero_wait_lu",      1, 1, 1, 0, 1, 5'd31, 0, 5'd0, 1, 5'd31, 0, O_REQ | O_LU);
        tbl[13] = mk("zero_wait_branch",  1, 1, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, O_REQ | O_BR);

        rst_n = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0; ex_branch_taken = 1'b0;
        ex_mem_read = 1'b0; ex_reg_w_addr = '0; id_uses_rs = 1'b0; id_rs_addr = '0;
        id_uses_rt = 1'b0; id_rt_addr = '0; id_rt_store_only = 1'b0;

        for (int i = 0; i < 14; i++) apply(tbl[i]);

        // Three wait states, ack in the 4th cycle, then confirm back in RUN
        apply(mm("ws3_c1", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("ws3_c2", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("ws3_c3", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("ws3_ack", 1, 1, 1, 0, O_REQ));
        apply(mm("ws3_idle", 1, 0, 0, 0, O_NONE));
        apply(mm("ws3_run_again", 1, 1, 1, 0, O_REQ));

        // Taken branch during a memory stall: held until ack, flushed on the ack cycle
        apply(mm("brms_c1", 1, 1, 0, 1, O_REQ | O_MS));
        apply(mm("brms_c2", 1, 1, 0, 1, O_REQ | O_MS));
        apply(mm("brms_ack", 1, 1, 1, 1, O_REQ | O_BR));
        apply(mm("brms_idle", 1, 0, 0, 0, O_NONE));

        // Ack on the last allowed wait cycle still completes normally
        apply(mm("edge_c1", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("edge_c2", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("edge_c3", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("edge_c4", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("edge_ack_at_limit", 1, 1, 1, 0, O_REQ));
        apply(mm("edge_idle", 1, 0, 0, 0, O_NONE));
        apply(mm("edge_run_again", 1, 1, 1, 0, O_REQ));

        // Watchdog expiry: ERR after the last allowed wait cycle, sticky until reset
        apply(mm("wd_c1", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("wd_c2", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("wd_c3", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("wd_c4", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("wd_c5_limit", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("wd_err", 1, 1, 1, 0, O_ERR));
        apply(mm("wd_err_branch", 1, 0, 0, 1, O_ERR));
        apply(mm("wd_err_sticky", 1, 0, 1, 0, O_ERR));
        apply(mm("wd_reset", 0, 1, 0, 1, O_NONE));
        apply(mm("wd_after_reset", 1, 0, 0, 0, O_NONE));
        apply(mm("wd_run_after_rst", 1, 1, 1, 0, O_REQ));

        // Reset in the middle of WAIT abandons the request at once
        apply(mm("rstw_c1", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("rstw_c2", 1, 1, 0, 0, O_REQ | O_MS));
        apply(mm("rstw_reset", 0, 1, 0, 0, O_NONE));
        apply(mm("rstw_idle", 1, 0, 0, 0, O_NONE));
        apply(mm("rstw_run", 1, 1, 1, 0, O_REQ));

        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
